gpio_ctrl: RTL and testbench
============================

// Module: gpio_ctrl
// PURPOSE
// Parametrised bus-mapped GPIO controller; next generation of the fixed 32-bit output-only IO port.
// Adds per-pin direction, synchronised input sampling, atomic set/clear, edge-detect interrupt.
// Sits on the peripheral data/control bus beside the other memory-mapped peripherals.
// irq feeds the core's fast interrupt input.
// PARAMETERS
// N_IO        32     number of GPIO pins, 1..32; register bits [31:N_IO] read 0, writes ignored
// ADDR_W      8      width of bus_addr (byte address within block), >=5
// SYNC_STAGES 2      input synchroniser depth, 2..4
// OUT_RST     '0     reset value of OUT register [N_IO-1:0]
// PORTS
// Clk        in   1        clock, all logic rising-edge
// Rst        in   1        synchronous active-high reset
// bus_req    in   1        access request; each cycle high = one access
// bus_we     in   1        1 = write, 0 = read
// bus_addr   in   ADDR_W   byte address
// bus_be     in   4        byte enables for writes
// bus_wdata  in   32       write data
// bus_gnt    out  1        grant, registered
// bus_rvalid out  1        response valid, registered
// bus_rdata  out  32       read data, valid with bus_rvalid
// bus_err    out  1        error response, valid with bus_rvalid
// io_out     out  N_IO     pin output values (= OUT)
// io_oe      out  N_IO     pin output enables (= DIR, 1 = drive)
// io_in      in   N_IO     asynchronous pin inputs
// irq        out  1        level interrupt, registered
// BEHAVIOUR
// Reset: OUT=OUT_RST, DIR/RISE_EN/FALL_EN/STATUS=0, sync chain and prev=0, gnt/rvalid/err/irq=0, rdata=0.
// Bus: gnt and rvalid = bus_req delayed 1 cycle; back-to-back accesses every cycle, no stalls.
// Register writes take effect on the clock edge where bus_req is sampled.
// bus_rdata/bus_err registered on that same edge. Write response rdata=0.
// Map (addr[4:2]; addr[1:0] ignored):
//   0x00 OUT rw; 0x04 DIR rw; 0x08 IN ro (synchronised pins, all pins regardless of DIR)
//   0x0C RISE_EN rw; 0x10 FALL_EN rw; 0x14 STATUS rw1c
//   0x18 OUT_SET wo (OUT |= wdata); 0x1C OUT_CLR wo (OUT &= ~wdata); both read 0
// bus_err=1 when addr[ADDR_W-1:5]!=0; such access has no side effect, rdata=0.
// Writes to IN: ignored, no error.
// Byte enables mask every write, including W1C/SET/CLR. be=0 write is acked with no effect.
// Input path: io_in -> SYNC_STAGES flops -> sync; prev <= sync each cycle.
// rise = sync & ~prev & RISE_EN; fall = ~sync & prev & FALL_EN.
// STATUS[i] set on rise[i]|fall[i]; same-cycle W1C clear and new event: set wins.
// Arm counter: edge detection masked for first SYNC_STAGES+1 cycles after Rst deasserts.
//   Levels present at reset raise no events. Counter saturates; then detection is live.
// irq <= |(STATUS & (RISE_EN|FALL_EN)), 1-cycle registered.
//   Clearing an enable masks irq without clearing STATUS.
// Edge-to-STATUS latency: io_in change to STATUS bit = SYNC_STAGES+1 cycles; irq one cycle later.
// Rst asserted mid-access: no response for in-flight request; all state returns to reset values next edge.
// TESTING
// Reset with io_in=all 1 -> no STATUS bits, irq=0 after 10 cycles; read IN -> 0xFFFF_FFFF (N_IO=32).
// Write OUT=0x1234_5678 be=4'b0101 after reset -> OUT=0x0034_0078; rvalid/gnt 1 cycle after req, rdata=0.
// OUT=0x0F; OUT_SET 0xF0; OUT_CLR 0x03 -> io_out=0xFC, read OUT=0xFC; DIR=0xFF -> io_oe=0xFF.
// RISE_EN[3]=1; io_in[3] 0->1 -> STATUS=0x8 after SYNC_STAGES+1 cycles, irq 1 cycle later;
//   W1C 0x8 -> irq drops.
// Rising edge on pin 0 in same cycle as W1C of bit 0 -> STATUS[0] stays 1.
// Read addr 0x20 with ADDR_W=8 -> bus_err=1, rdata=0. Back-to-back reads of 0x00,0x04,0x08
//   -> three consecutive rvalid cycles with correct data.

Source files
------------

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: bus-mapped GPIO controller with per-pin direction, synchronised
// inputs, atomic set/clear of the output register and edge-detect interrupt.
module gpio_ctrl #(
   parameter int              N_IO        = 32,
   parameter int              ADDR_W      = 8,
   parameter int              SYNC_STAGES = 2,
   parameter logic [N_IO-1:0] OUT_RST     = '0
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              bus_req,
   input  logic              bus_we,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [3:0]        bus_be,
   input  logic [31:0]       bus_wdata,
   output logic              bus_gnt,
   output logic              bus_rvalid,
   output logic [31:0]       bus_rdata,
   output logic              bus_err,
   output logic [N_IO-1:0]   io_out,
   output logic [N_IO-1:0]   io_oe,
   input  logic [N_IO-1:0]   io_in,
   output logic              irq
);

   localparam logic [2:0] A_OUT    = 3'd0;
   localparam logic [2:0] A_DIR    = 3'd1;
   localparam logic [2:0] A_IN     = 3'd2;
   localparam logic [2:0] A_RISE   = 3'd3;
   localparam logic [2:0] A_FALL   = 3'd4;
   localparam logic [2:0] A_STATUS = 3'd5;
   localparam logic [2:0] A_SET    = 3'd6;
   localparam logic [2:0] A_CLR    = 3'd7;

   // Edge detection stays masked until the synchroniser has flushed its
   // reset contents, so levels already present at reset raise no events.
   localparam int ARM_LEN = SYNC_STAGES + 1;

   logic [N_IO-1:0] out_r;
   logic [N_IO-1:0] dir_r;
   logic [N_IO-1:0] rise_en_r;
   logic [N_IO-1:0] fall_en_r;
   logic [N_IO-1:0] status_r;
   logic [N_IO-1:0] status_nx;
   logic [N_IO-1:0] sync_p [SYNC_STAGES];
   logic [N_IO-1:0] prev_p;
   logic [N_IO-1:0] sync_in;
   logic [N_IO-1:0] rise;
   logic [N_IO-1:0] fall;
   logic [2:0]      arm_cnt;
   logic            armed;
   logic [31:0]     be_mask;
   logic [N_IO-1:0] wmask;
   logic [N_IO-1:0] wbits;
   logic [31:0]     rd_val;
   logic [2:0]      reg_sel;
   logic            addr_err;
   logic            wr_en;
   logic            unused_bits;

   // Any address bit above the 32-byte window flags an error response.
   generate
      if (ADDR_W > 5) begin : g_hi_addr
         assign addr_err = |bus_addr[ADDR_W-1:5];
      end else begin : g_no_hi_addr
         assign addr_err = 1'b0;
      end
   endgenerate

   assign unused_bits = &{1'b0, bus_addr[1:0]};
   assign reg_sel     = bus_addr[4:2];
   assign wr_en       = bus_req & bus_we & ~addr_err;
   assign sync_in     = sync_p[SYNC_STAGES-1];
   assign armed       = (arm_cnt == 3'(ARM_LEN));
   assign rise        = sync_in & ~prev_p & rise_en_r & {N_IO{armed}};
   assign fall        = ~sync_in & prev_p & fall_en_r & {N_IO{armed}};
   assign io_out      = out_r;
   assign io_oe       = dir_r;

   // Byte-enable mask applied to every write, including set/clear/W1C.
   always_comb begin
      be_mask = {{8{bus_be[3]}}, {8{bus_be[2]}}, {8{bus_be[1]}}, {8{bus_be[0]}}};
      wmask   = be_mask[N_IO-1:0];
      wbits   = bus_wdata[N_IO-1:0] & wmask;
   end

   // STATUS next value: W1C first, then new events so a same-cycle event wins.
   always_comb begin
      status_nx = status_r;
      if (wr_en && (reg_sel == A_STATUS)) status_nx = status_r & ~wbits;
      status_nx = status_nx | rise | fall;
   end

   // Read mux; write-only and out-of-window locations return zero.
   always_comb begin
      rd_val = '0;
      if (!addr_err) begin
         case (reg_sel)
            A_OUT:    rd_val[N_IO-1:0] = out_r;
            A_DIR:    rd_val[N_IO-1:0] = dir_r;
            A_IN:     rd_val[N_IO-1:0] = sync_in;
            A_RISE:   rd_val[N_IO-1:0] = rise_en_r;
            A_FALL:   rd_val[N_IO-1:0] = fall_en_r;
            A_STATUS: rd_val[N_IO-1:0] = status_r;
            default:  rd_val = '0;
         endcase
      end
   end

   // Input synchroniser chain and previous-sample register for edge detection.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
         prev_p <= '0;
      end else begin
         sync_p[0] <= io_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
         prev_p <= sync_in;
      end
   end

   // Control/status registers, arm counter and interrupt output.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         out_r     <= OUT_RST;
         dir_r     <= '0;
         rise_en_r <= '0;
         fall_en_r <= '0;
         status_r  <= '0;
         arm_cnt   <= '0;
         irq       <= 1'b0;
      end else begin
         if (!armed) arm_cnt <= arm_cnt + 3'd1;
         status_r <= status_nx;
         irq      <= |(status_r & (rise_en_r | fall_en_r));
         if (wr_en) begin
            case (reg_sel)
               A_OUT:   out_r     <= (out_r & ~wmask) | wbits;
               A_DIR:   dir_r     <= (dir_r & ~wmask) | wbits;
               A_RISE:  rise_en_r <= (rise_en_r & ~wmask) | wbits;
               A_FALL:  fall_en_r <= (fall_en_r & ~wmask) | wbits;
               A_SET:   out_r     <= out_r | wbits;
               A_CLR:   out_r     <= out_r & ~wbits;
               default: ;
            endcase
         end
      end
   end

   // Bus response: one registered response per request, no stalls.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         bus_gnt    <= 1'b0;
         bus_rvalid <= 1'b0;
         bus_err    <= 1'b0;
         bus_rdata  <= '0;
      end else begin
         bus_gnt    <= bus_req;
         bus_rvalid <= bus_req;
         bus_err    <= bus_req & addr_err;
         bus_rdata  <= (bus_req && !bus_we) ? rd_val : 32'd0;
      end
   end

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed bench for gpio_ctrl with a response scoreboard.
module tb_gpio_ctrl;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        bus_req = 1'b0;
   logic        bus_we = 1'b0;
   logic [7:0]  bus_addr = '0;
   logic [3:0]  bus_be = '0;
   logic [31:0] bus_wdata = '0;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic        bus_err;
   logic [31:0] io_out;
   logic [31:0] io_oe;
   logic [31:0] io_in = '1;
   logic        irq;

   int          total = 0;
   int          bad = 0;
   logic        mon_en = 1'b0;
   logic        req_d = 1'b0;
   string       tag_q[$];
   logic [32:0] exp_q[$];

   gpio_ctrl #(.N_IO(32), .ADDR_W(8), .SYNC_STAGES(2), .OUT_RST('0)) dut (
      .Clk(Clk), .Rst(Rst),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata), .bus_err(bus_err),
      .io_out(io_out), .io_oe(io_oe), .io_in(io_in), .irq(irq)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference for response timing: one response per request, one cycle later.
   always @(posedge Clk) req_d <= Rst ? 1'b0 : bus_req;

   // Response monitor: pops the scoreboard whenever the DUT responds.
   always @(negedge Clk) begin
      if (mon_en) begin
         check("rvalid_timing", 32'(bus_rvalid), 32'(req_d));
         check("gnt_timing", 32'(bus_gnt), 32'(req_d));
         if (bus_rvalid) begin
            check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               string       t;
               logic [32:0] e;
               t = tag_q.pop_front();
               e = exp_q.pop_front();
               check({t, "_rdata"}, bus_rdata, e[31:0]);
               check({t, "_err"}, 32'(bus_err), 32'(e[32]));
            end
         end
      end
   end

   task automatic drive(input string tag, input logic we, input logic [7:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
      @(negedge Clk);
      bus_req   = 1'b1;
      bus_we    = we;
      bus_addr  = addr;
      bus_be    = be;
      bus_wdata = wd;
      tag_q.push_back(tag);
      exp_q.push_back({exp_err, exp_rd});
   endtask

   task automatic idle();
      @(negedge Clk);
      bus_req = 1'b0;
      bus_we  = 1'b0;
   endtask

   initial begin
      // Reset with all pins high
      repeat (3) @(negedge Clk);
      mon_en = 1'b1;
      check("rst_io_out", io_out, 32'h0);
      check("rst_io_oe", io_oe, 32'h0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rdata", bus_rdata, 32'h0);
      check("rst_err", 32'(bus_err), 32'd0);
      Rst = 1'b0;
      repeat (10) @(negedge Clk);
      check("arm_irq", 32'(irq), 32'd0);
      drive("arm_status", 1'b0, 8'h14, 4'h0, 32'h0, 32'h0, 1'b0);
      drive("rd_in_ones", 1'b0, 8'h08, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
      idle();
      io_in = 32'h0;
      repeat (4) @(negedge Clk);

      // Byte-enabled write, then a write with no byte enables
      drive("wr_out_be", 1'b1, 8'h00, 4'b0101, 32'h1234_5678, 32'h0, 1'b0);
      drive("rd_out_be", 1'b0, 8'h00, 4'h0, 32'h0, 32'h0034_0078, 1'b0);
      idle();
      check("io_out_be", io_out, 32'h0034_0078);
      drive("wr_out_be0", 1'b1, 8'h00, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
      drive("rd_out_be0", 1'b0, 8'h00, 4'h0, 32'h0, 32'h0034_0078, 1'b0);

      // Atomic set/clear and direction
      drive("wr_out", 1'b1, 8'h00, 4'hF, 32'h0F, 32'h0, 1'b0);
      drive("wr_set", 1'b1, 8'h18, 4'hF, 32'hF0, 32'h0, 1'b0);
      drive("wr_clr", 1'b1, 8'h1C, 4'hF, 32'h03, 32'h0, 1'b0);
      drive("rd_out_sc", 1'b0, 8'h00, 4'h0, 32'h0, 32'hFC, 1'b0);
      drive("rd_set", 1'b0, 8'h18, 4'h0, 32'h0, 32'h0, 1'b0);
      drive("wr_dir", 1'b1, 8'h04, 4'hF, 32'hFF, 32'h0, 1'b0);
      idle();
      check("io_out_sc", io_out, 32'hFC);
      check("io_oe_dir", io_oe, 32'hFF);

      // Rising edge on pin 3: STATUS after 3 cycles, irq one later
      drive("wr_rise3", 1'b1, 8'h0C, 4'hF, 32'h8, 32'h0, 1'b0);
      idle();
      io_in[3] = 1'b1;
      @(negedge Clk); check("rise_irq_c1", 32'(irq), 32'd0);
      @(negedge Clk); check("rise_irq_c2", 32'(irq), 32'd0);
      @(negedge Clk); check("rise_irq_c3", 32'(irq), 32'd0);
      @(negedge Clk); check("rise_irq_c4", 32'(irq), 32'd1);
      drive("rd_status8", 1'b0, 8'h14, 4'h0, 32'h0, 32'h8, 1'b0);
      drive("w1c_status8", 1'b1, 8'h14, 4'hF, 32'h8, 32'h0, 1'b0);
      idle();
      check("w1c_irq_hold", 32'(irq), 32'd1);
      @(negedge Clk); check("w1c_irq_drop", 32'(irq), 32'd0);
      drive("rd_status0", 1'b0, 8'h14, 4'h0, 32'h0, 32'h0, 1'b0);

      // Falling edge on pin 3, then masking irq by clearing the enable
      drive("wr_rise0", 1'b1, 8'h0C, 4'hF, 32'h0, 32'h0, 1'b0);
      drive("wr_fall3", 1'b1, 8'h10, 4'hF, 32'h8, 32'h0, 1'b0);
      idle();
      io_in[3] = 1'b0;
      repeat (5) @(negedge Clk);
      check("fall_irq", 32'(irq), 32'd1);
      drive("wr_fall0", 1'b1, 8'h10, 4'hF, 32'h0, 32'h0, 1'b0);
      idle();
      @(negedge Clk); check("mask_irq", 32'(irq), 32'd0);
      drive("rd_status_kept", 1'b0, 8'h14, 4'h0, 32'h0, 32'h8, 1'b0);
      drive("w1c_fall", 1'b1, 8'h14, 4'hF, 32'h8, 32'h0, 1'b0);

      // Event on pin 0 in the same cycle as W1C of bit 0: set wins
      drive("wr_rise_p0", 1'b1, 8'h0C, 4'hF, 32'h1, 32'h0, 1'b0);
      idle();
      io_in[0] = 1'b1;
      @(negedge Clk);
      drive("w1c_race", 1'b1, 8'h14, 4'hF, 32'h1, 32'h0, 1'b0);
      idle();
      drive("rd_race", 1'b0, 8'h14, 4'h0, 32'h0, 32'h1, 1'b0);
      drive("w1c_p0", 1'b1, 8'h14, 4'hF, 32'h1, 32'h0, 1'b0);
      drive("rd_p0_clr", 1'b0, 8'h14, 4'h0, 32'h0, 32'h0, 1'b0);

      // Out-of-window accesses
      drive("rd_err", 1'b0, 8'h20, 4'h0, 32'h0, 32'h0, 1'b1);
      drive("wr_err", 1'b1, 8'h20, 4'hF, 32'h0, 32'h0, 1'b1);
      drive("wr_in", 1'b1, 8'h08, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0);
      idle();
      check("io_out_err", io_out, 32'hFC);

      // Back-to-back reads
      drive("b2b_out", 1'b0, 8'h00, 4'h0, 32'h0, 32'hFC, 1'b0);
      drive("b2b_dir", 1'b0, 8'h04, 4'h0, 32'h0, 32'hFF, 1'b0);
      drive("b2b_in", 1'b0, 8'h08, 4'h0, 32'h0, 32'h1, 1'b0);
      idle();
      repeat (3) @(negedge Clk);
      check("rsp_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
